// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// func3 access-size codes, the default bus timeout and an alignment helper.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // size is func3[1:0]: 00 byte, 01 halfword, anything else treated as word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational data steering between the core and a 32-bit bus.
// Store side: byte-enable generation and lane replication.
// Load side : byte/halfword extraction with sign or zero extension.
//
// Ports
//   i_func3   : access size/sign code
//   i_addr_lo : low two bits of the byte address
//   i_we      : 1 = store, 0 = load (loads always enable all four lanes)
//   i_wdata   : raw store data (rs2)
//   i_rdata   : raw bus read word
//   o_be      : bus byte enables
//   o_wdata   : lane-replicated store word
//   o_rdata   : extracted and extended load result
// -----------------------------------------------------------------------------
module mem_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statements can leave it unassigned (latch).
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_we) begin
            case (i_func3[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rdata = i_rdata;
        case (i_func3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'h0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Three-state (IDLE/ACCESS/DONE) sequencer that turns a load or store from the
// pipeline into a single request on a ready-handshake 32-bit bus, stalling the
// core until the access retires. Misaligned accesses never reach the bus, and
// an access whose ready does not arrive within TIMEOUT_CYCLES is aborted.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   MemRead/Write   : load / store request from the current instruction
//   func3           : access size and sign
//   addr, w_data    : byte address and store data
//   stall           : hold PC / block writeback
//   load_data       : registered, extended load result
//   misaligned      : one-cycle pulse after a misaligned request
//   bus_error       : one-cycle pulse in DONE after a timeout
//   bus_*           : request/ready bus master port
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned     CW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

    lsu_state_e    r_state, w_state_next;
    logic [CW-1:0] r_count;
    logic [31:0]   r_addr, r_wdata, r_load_data;
    logic [2:0]    r_func3;
    logic          r_we, r_misaligned, r_bus_error;

    logic          w_req, w_aligned, w_start, w_timeout;
    logic [CW-1:0] w_count_inc;
    logic [31:0]   w_load_ext;

    assign w_req       = MemRead | MemWrite;
    assign w_aligned   = is_aligned(func3[1:0], addr[1:0]);
    assign w_start     = (r_state == IDLE) && w_req && w_aligned;
    assign w_count_inc = r_count + 1'b1;
    // A ready in the last allowed cycle still completes normally.
    assign w_timeout   = (r_state == ACCESS) && !bus_ready && (w_count_inc == TIMEOUT_VAL);

    // Steering runs from the latched request so the bus stays stable while waiting.
    mem_align u_mem_align (
        .i_func3   (r_func3),
        .i_addr_lo (r_addr[1:0]),
        .i_we      (r_we),
        .i_wdata   (r_wdata),
        .i_rdata   (bus_rdata),
        .o_be      (bus_be),
        .o_wdata   (bus_wdata),
        .o_rdata   (w_load_ext)
    );

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = ACCESS;
                    stall        = 1'b1;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus_ready || w_timeout) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_func3      <= '0;
            r_we         <= 1'b0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_misaligned <= (r_state == IDLE) && w_req && !w_aligned;
            r_bus_error  <= w_timeout;
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (w_start) begin
                        r_addr  <= addr;
                        r_wdata <= w_data;
                        r_func3 <= func3;
                        r_we    <= MemWrite;
                    end
                end
                ACCESS: begin
                    r_count <= w_count_inc;
                    if (bus_ready && !r_we) r_load_data <= w_load_ext;
                    else if (w_timeout)     r_load_data <= '0;
                end
                default: r_count <= '0;
            endcase
        end
    end

    // bus_req decodes the state register directly, so an async reset drops it at once.
    assign bus_req    = (r_state == ACCESS);
    assign bus_we     = bus_req & r_we;
    assign bus_addr   = {r_addr[31:2], 2'b00};
    assign load_data  = r_load_data;
    assign misaligned = r_misaligned;
    assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [2:0]  func3;
    logic [31:0] addr, w_data;
    logic        stall, misaligned, bus_error;
    logic [31:0] load_data;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .func3     (func3),
        .addr      (addr),
        .w_data    (w_data),
        .stall     (stall),
        .load_data (load_data),
        .misaligned(misaligned),
        .bus_error (bus_error),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_mis;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_load;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic mis,
                                input logic [31:0] ba, input logic [3:0] be,
                                input logic [31:0] bw, input logic [31:0] ld);
        vec_t v;
        v.is_store = st; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.exp_mis = mis; v.exp_baddr = ba; v.exp_be = be; v.exp_bwdata = bw; v.exp_load = ld;
        return v;
    endfunction

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; func3 = f; addr = a; w_data = wd;
    endtask

    initial begin
        int cnt;
        //                 st    f3     addr          wdata         rdata         mis   baddr         be       bwdata        load
        vecs[0]  = mk(1'b0, F3_W,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF);
        vecs[1]  = mk(1'b0, F3_B,  32'h0000_0103, 32'h0,        32'h80FF_FF00, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80);
        vecs[2]  = mk(1'b0, F3_BU, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080);
        vecs[3]  = mk(1'b1, F3_H,  32'h0000_0202, 32'h1234_ABCD, 32'h0,        1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
        vecs[4]  = mk(1'b1, F3_B,  32'h0000_0201, 32'h0000_00A5, 32'h0,        1'b0, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0080);
        vecs[5]  = mk(1'b0, F3_H,  32'h0000_0102, 32'h0,        32'h8001_7FFF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_8001);
        vecs[6]  = mk(1'b0, F3_HU, 32'h0000_0100, 32'h0,        32'h8001_7FFF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_7FFF);
        vecs[7]  = mk(1'b1, F3_W,  32'h0000_0300, 32'hCAFE_F00D, 32'h0,        1'b0, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0000_7FFF);
        vecs[8]  = mk(1'b0, F3_W,  32'h0000_0101, 32'h0,        32'h1111_1111, 1'b1, 32'h0,        4'b0,    32'h0,        32'h0000_7FFF);
        vecs[9]  = mk(1'b0, F3_H,  32'h0000_0103, 32'h0,        32'h1111_1111, 1'b1, 32'h0,        4'b0,    32'h0,        32'h0000_7FFF);
        vecs[10] = mk(1'b1, F3_W,  32'h0000_0302, 32'h5555_5555, 32'h0,        1'b1, 32'h0,        4'b0,    32'h0,        32'h0000_7FFF);
        vecs[11] = mk(1'b1, F3_H,  32'h0000_0201, 32'h5555_5555, 32'h0,        1'b1, 32'h0,        4'b0,    32'h0,        32'h0000_7FFF);
        vecs[12] = mk(1'b0, F3_B,  32'h0000_0101, 32'h0,        32'h1234_5678, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0056);

        rst = 1'b1; bus_ready = 1'b0; bus_rdata = '0;
        drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        // Reset state
        #12;
        check("rst_stall",      {31'h0, stall},      32'h0);
        check("rst_bus_req",    {31'h0, bus_req},    32'h0);
        check("rst_load_data",  load_data,           32'h0);
        check("rst_misaligned", {31'h0, misaligned}, 32'h0);
        check("rst_bus_error",  {31'h0, bus_error},  32'h0);
        @(negedge clk); rst = 1'b0;

        // Table-driven accesses with bus_ready already high
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_req(!vecs[i].is_store, vecs[i].is_store, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            bus_rdata = vecs[i].rdata;
            bus_ready = 1'b1;
            #1;
            check($sformatf("v%0d_req_stall", i), {31'h0, stall}, {31'h0, !vecs[i].exp_mis});
            check($sformatf("v%0d_req_busreq", i), {31'h0, bus_req}, 32'h0);
            @(posedge clk); #1;
            drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
            if (vecs[i].exp_mis) begin
                check($sformatf("v%0d_mis_pulse", i), {31'h0, misaligned}, 32'h1);
                check($sformatf("v%0d_mis_busreq", i), {31'h0, bus_req}, 32'h0);
                check($sformatf("v%0d_mis_stall", i), {31'h0, stall}, 32'h0);
                @(posedge clk); #1;
                check($sformatf("v%0d_mis_end", i), {31'h0, misaligned}, 32'h0);
                check($sformatf("v%0d_mis_busreq2", i), {31'h0, bus_req}, 32'h0);
                check($sformatf("v%0d_load_hold", i), load_data, vecs[i].exp_load);
            end else begin
                check($sformatf("v%0d_acc_busreq", i), {31'h0, bus_req}, 32'h1);
                check($sformatf("v%0d_acc_stall", i), {31'h0, stall}, 32'h1);
                check($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].exp_baddr);
                check($sformatf("v%0d_bus_we", i), {31'h0, bus_we}, {31'h0, vecs[i].is_store});
                check($sformatf("v%0d_bus_be", i), {28'h0, bus_be}, {28'h0, vecs[i].exp_be});
                if (vecs[i].is_store)
                    check($sformatf("v%0d_bus_wdata", i), bus_wdata, vecs[i].exp_bwdata);
                check($sformatf("v%0d_acc_mis", i), {31'h0, misaligned}, 32'h0);
                @(posedge clk); #1;
                check($sformatf("v%0d_done_stall", i), {31'h0, stall}, 32'h0);
                check($sformatf("v%0d_done_busreq", i), {31'h0, bus_req}, 32'h0);
                check($sformatf("v%0d_load_data", i), load_data, vecs[i].exp_load);
                check($sformatf("v%0d_done_buserr", i), {31'h0, bus_error}, 32'h0);
                @(posedge clk);
            end
        end

        // Request held high through DONE must not restart from DONE
        @(negedge clk);
        drive_req(1'b1, 1'b0, F3_W, 32'h0000_0104, 32'h0);
        bus_rdata = 32'h1122_3344; bus_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_access", {31'h0, bus_req}, 32'h1);
        @(posedge clk); #1;
        check("hold_done_stall", {31'h0, stall}, 32'h0);
        check("hold_done_busreq", {31'h0, bus_req}, 32'h0);
        check("hold_load", load_data, 32'h1122_3344);
        @(posedge clk); #1;
        check("hold_idle_stall", {31'h0, stall}, 32'h1);
        check("hold_idle_busreq", {31'h0, bus_req}, 32'h0);
        drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        // Wait states: bus outputs hold steady until ready
        @(negedge clk);
        drive_req(1'b0, 1'b1, F3_H, 32'h0000_0106, 32'h0000_9876);
        bus_ready = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("wait%0d_busreq", k), {31'h0, bus_req}, 32'h1);
            check($sformatf("wait%0d_addr", k), bus_addr, 32'h0000_0104);
            check($sformatf("wait%0d_be", k), {28'h0, bus_be}, 32'hC);
            check($sformatf("wait%0d_wdata", k), bus_wdata, 32'h9876_9876);
            check($sformatf("wait%0d_stall", k), {31'h0, stall}, 32'h1);
            @(posedge clk); #1;
        end
        check("wait2_busreq", {31'h0, bus_req}, 32'h1);
        @(negedge clk); bus_ready = 1'b1;
        @(posedge clk); #1;
        check("wait_done_busreq", {31'h0, bus_req}, 32'h0);
        check("wait_store_keeps_load", load_data, 32'h1122_3344);
        check("wait_done_buserr", {31'h0, bus_error}, 32'h0);
        @(posedge clk);

        // Timeout after exactly 4 ACCESS cycles
        @(negedge clk);
        drive_req(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
        bus_ready = 1'b0; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        cnt = 0;
        while (bus_req && cnt < 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("to_access_cycles", cnt, 32'd4);
        check("to_bus_error", {31'h0, bus_error}, 32'h1);
        check("to_load_zero", load_data, 32'h0);
        check("to_done_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        check("to_error_end", {31'h0, bus_error}, 32'h0);

        // Reset during the third ACCESS cycle
        @(negedge clk);
        drive_req(1'b1, 1'b0, F3_W, 32'h0000_0108, 32'h0);
        bus_ready = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("pre_rst_load", load_data, 32'h5A5A_5A5A);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b1, 1'b0, F3_W, 32'h0000_010C, 32'h0);
        bus_ready = 1'b0; bus_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("acc3_busreq", {31'h0, bus_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_busreq", {31'h0, bus_req}, 32'h0);
        check("abort_stall", {31'h0, stall}, 32'h0);
        check("abort_load_zero", load_data, 32'h0);
        bus_ready = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busreq", {31'h0, bus_req}, 32'h0);
        check("post_rst_load", load_data, 32'h0);

        // Recovery: a normal load completes after the abort
        @(negedge clk);
        drive_req(1'b1, 1'b0, F3_W, 32'h0000_0110, 32'h0);
        bus_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        check("rec_busreq", {31'h0, bus_req}, 32'h1);
        check("rec_addr", bus_addr, 32'h0000_0110);
        @(posedge clk); #1;
        check("rec_load", load_data, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
